// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the DMEM load/store unit: access sizes, FSM states
// and the lane-select helpers used by the lane mux.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Bit offset of the addressed lane inside the 32-bit word (little-endian)
    function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                              input logic [1:0] size);
        if (size == SZ_HALF) begin
            return {offset[1], 4'b0000};
        end
        return {offset, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU-side request/response signals and DMEM-side bus of the load/store unit.
interface dmem_lsu_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        addr_err;
    logic        busy;
    logic        dm_cs;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    // The LSU itself
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, dm_rdata,
        output rdata, done, addr_err, busy, dm_cs, dm_r, dm_w, dm_addr, dm_wdata
    );

    // The CPU datapath and the DMEM seen together from outside the LSU
    modport master (
        output req, we, size, sign_ext, addr, wdata, dm_rdata,
        input  rdata, done, addr_err, busy, dm_cs, dm_r, dm_w, dm_addr, dm_wdata
    );

endinterface

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic: extracts and extends load data from a DMEM word,
// and merges sub-word store data into a DMEM word for read-modify-write.
module lsu_lane_mux
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    // Shift the addressed lane down for loads and up for store merges
    always_comb begin
        shift     = lane_shift(offset, size);
        shifted   = rd_word >> shift;
        lane_mask = (size == SZ_HALF) ? HALF_MASK : BYTE_MASK;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
        merge_data = (rd_word & ~(lane_mask << shift)) |
                     ((wr_data & lane_mask) << shift);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU datapath and a word-only DMEM. Handles
// byte/half/word accesses, sub-word read-modify-write and address errors.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic      clk,
    input  logic      rst,
    dmem_lsu_if.slave bus
);

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

    state_e      state;
    state_e      next_state;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_sext;
    logic [31:0] lat_wdata;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_wait;
    logic        bad_req;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        busy_c;
    logic        cs_c;
    logic        r_c;
    logic        w_c;
    logic        done_c;
    logic        err_c;

    lsu_lane_mux u_lane_mux (
        .offset     (lat_addr[1:0]),
        .size       (lat_size),
        .sign_ext   (lat_sext),
        .rd_word    (bus.dm_rdata),
        .wr_data    (lat_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Classify an incoming request as misaligned, reserved-size or out of range
    always_comb begin
        bad_req = 1'b0;
        if (bus.size == SZ_RSVD) bad_req = 1'b1;
        if (bus.size == SZ_HALF && bus.addr[0]) bad_req = 1'b1;
        if (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00) bad_req = 1'b1;
        if (bus.addr[31:2] >= DEPTH_IDX) bad_req = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and Moore outputs; errors wait one extra cycle in ERR so
    // they complete with the same latency as a load
    always_comb begin
        next_state = state;
        busy_c     = 1'b1;
        cs_c       = 1'b0;
        r_c        = 1'b0;
        w_c        = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.req) begin
                    if (bad_req)                next_state = ERR;
                    else if (!bus.we)           next_state = LOAD;
                    else if (bus.size == SZ_WORD) next_state = WRITE;
                    else                        next_state = RMW_RD;
                end
            end
            LOAD: begin
                cs_c       = 1'b1;
                r_c        = 1'b1;
                next_state = DONE;
            end
            RMW_RD: begin
                cs_c       = 1'b1;
                r_c        = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                cs_c       = 1'b1;
                w_c        = lat_we;
                next_state = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                if (!err_wait) begin
                    done_c     = 1'b1;
                    err_c      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the request fields when a request is accepted in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_sext  <= 1'b0;
            lat_wdata <= '0;
        end else if (state == IDLE && bus.req) begin
            lat_addr  <= bus.addr;
            lat_we    <= bus.we;
            lat_size  <= bus.size;
            lat_sext  <= bus.sign_ext;
            lat_wdata <= bus.wdata;
        end
    end

    // Track the first of the two ERR cycles
    always_ff @(posedge clk) begin
        if (rst)                                   err_wait <= 1'b0;
        else if (state == IDLE && bus.req && bad_req) err_wait <= 1'b1;
        else if (state == ERR)                     err_wait <= 1'b0;
    end

    // Capture load results and read-modify-write merge words
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            merge_q <= '0;
        end else if (state == LOAD) begin
            rdata_q <= load_data;
        end else if (state == RMW_RD) begin
            merge_q <= merge_data;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.done     = done_c;
    assign bus.addr_err = err_c;
    assign bus.busy     = busy_c;
    assign bus.dm_cs    = cs_c;
    assign bus.dm_r     = r_c;
    assign bus.dm_w     = w_c;
    assign bus.dm_addr  = {lat_addr[31:2], 2'b00};
    assign bus.dm_wdata = (state != WRITE)       ? 32'h0 :
                          (lat_size == SZ_WORD)  ? lat_wdata : merge_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a 64-word DMEM model.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic [31:0] mem [64];
    int          checks;
    int          errors;

    dmem_lsu_if bus ();

    dmem_lsu #(.DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM model: combinational read, write commits on the closing edge
    assign bus.dm_rdata = mem[bus.dm_addr[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[3]  <= 32'h8899AABB;
            mem[63] <= 32'h5A5AA5A5;
        end else if (bus.dm_cs && bus.dm_w) begin
            mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and record, per cycle after acceptance, strobes and done
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic sext, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output int done_cyc, output int r_cyc,
                                 output int w_cyc, output int cs_cnt,
                                 output logic err_at_done);
        @(negedge clk);
        bus.req      = 1'b1;
        bus.we       = we;
        bus.size     = size;
        bus.sign_ext = sext;
        bus.addr     = addr;
        bus.wdata    = wdata;
        @(posedge clk);
        #1 bus.req = 1'b0;
        done_cyc    = 0;
        r_cyc       = 0;
        w_cyc       = 0;
        cs_cnt      = 0;
        err_at_done = 1'b0;
        for (int k = 1; k <= 8 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (bus.dm_cs) cs_cnt++;
            if (bus.dm_r && r_cyc == 0) r_cyc = k;
            if (bus.dm_w && w_cyc == 0) w_cyc = k;
            if (bus.done) begin
                done_cyc    = k;
                err_at_done = bus.addr_err;
            end
        end
    endtask

    int   d_cyc, r_cyc, w_cyc, cs_cnt;
    logic err;
    int   reads_first, second_read, done_cnt;
    logic saw_done, saw_w;

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        mem_init     = 1'b1;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.size     = 2'b00;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        checkOutput("rst_done", {31'h0, bus.done}, 32'h0);
        checkOutput("rst_err", {31'h0, bus.addr_err}, 32'h0);
        checkOutput("rst_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("rst_strobes", {29'h0, bus.dm_cs, bus.dm_r, bus.dm_w}, 32'h0);
        checkOutput("rst_dm_addr", bus.dm_addr, 32'h0);
        checkOutput("rst_dm_wdata", bus.dm_wdata, 32'h0);
        rst      = 1'b0;
        mem_init = 1'b0;

        // Byte load, sign-extended
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lb_done_cyc", d_cyc, 2);
        checkOutput("lb_err", {31'h0, err}, 32'h0);
        checkOutput("lb_r_cyc", r_cyc, 1);
        checkOutput("lb_rdata", bus.rdata, 32'hFFFFFFAA);

        // Half load, zero-extended
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lh_done_cyc", d_cyc, 2);
        checkOutput("lh_rdata", bus.rdata, 32'h00008899);

        // Word load
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lw_done_cyc", d_cyc, 2);
        checkOutput("lw_rdata", bus.rdata, 32'h8899AABB);

        // Byte store via read-modify-write
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0C, 32'h12345677, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("sb_r_cyc", r_cyc, 1);
        checkOutput("sb_w_cyc", w_cyc, 2);
        checkOutput("sb_done_cyc", d_cyc, 3);
        checkOutput("sb_mem3", mem[3], 32'h8899AA77);
        checkOutput("sb_rdata_hold", bus.rdata, 32'h8899AABB);

        // Half store to upper half
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0E, 32'hCAFE1234, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("sh_done_cyc", d_cyc, 3);
        checkOutput("sh_mem3", mem[3], 32'h1234AA77);

        // Byte load of top lane, and signed half load of low half
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lb3_rdata", bus.rdata, 32'h00000012);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lh0_rdata", bus.rdata, 32'hFFFFAA77);

        // Word store never reads
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("sw_r_cyc", r_cyc, 0);
        checkOutput("sw_w_cyc", w_cyc, 1);
        checkOutput("sw_done_cyc", d_cyc, 2);
        checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);

        // Last valid word index
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("lw63_err", {31'h0, err}, 32'h0);
        checkOutput("lw63_rdata", bus.rdata, 32'h5A5AA5A5);

        // Error cases: misaligned half, out-of-range word store, reserved size
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("emis_done_cyc", d_cyc, 2);
        checkOutput("emis_err", {31'h0, err}, 32'h1);
        checkOutput("emis_cs", cs_cnt, 0);
        checkOutput("emis_rdata", bus.rdata, 32'h5A5AA5A5);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("eoor_done_cyc", d_cyc, 2);
        checkOutput("eoor_err", {31'h0, err}, 32'h1);
        checkOutput("eoor_cs", cs_cnt, 0);
        checkOutput("eoor_mem0", mem[0], 32'h0);

        applyStimulus(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, d_cyc, r_cyc, w_cyc, cs_cnt, err);
        checkOutput("ersv_done_cyc", d_cyc, 2);
        checkOutput("ersv_err", {31'h0, err}, 32'h1);
        checkOutput("ersv_cs", cs_cnt, 0);
        checkOutput("ersv_rdata", bus.rdata, 32'h5A5AA5A5);
        checkOutput("ersv_mem3", mem[3], 32'h1234AA77);

        // Reset during RMW_RD of a half store
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.size  = 2'b01;
        bus.addr  = 32'h0C;
        bus.wdata = 32'h0000FFFF;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        checkOutput("rmw_in_read", {31'h0, bus.dm_r}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        saw_done = 1'b0;
        saw_w    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("rmwrst_busy", {31'h0, bus.busy}, 32'h0);
            if (bus.done) saw_done = 1'b1;
            if (bus.dm_w) saw_w = 1'b1;
        end
        checkOutput("rmwrst_no_done", {31'h0, saw_done}, 32'h0);
        checkOutput("rmwrst_no_write", {31'h0, saw_w}, 32'h0);
        checkOutput("rmwrst_mem3", mem[3], 32'h1234AA77);

        // req held high: one access, next accepted only after IDLE
        @(negedge clk);
        bus.req      = 1'b1;
        bus.we       = 1'b0;
        bus.size     = 2'b10;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h0C;
        @(posedge clk);
        reads_first = 0;
        second_read = 0;
        done_cnt    = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.dm_r && k <= 3) reads_first++;
            if (bus.dm_r && k > 3 && second_read == 0) second_read = k;
            if (bus.done) done_cnt++;
        end
        bus.req = 1'b0;
        checkOutput("held_reads_first", reads_first, 1);
        checkOutput("held_second_read", second_read, 4);
        checkOutput("held_done_cnt", done_cnt, 2);
        checkOutput("held_rdata", bus.rdata, 32'h1234AA77);
        @(negedge clk);
        checkOutput("held_idle", {31'h0, bus.busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the CPU datapath and the word-only DMEM. Accepts byte, halfword and word load/store requests over a req/done handshake. Extracts and extends load data, performs read-modify-write for sub-word stores, and flags misaligned or out-of-range addresses. Drives the DMEM chip-select, read, write, address and data inputs, and consumes the DMEM combinational read data.

Parameters:
DEPTH, 64, number of 32-bit words in the attached DMEM; word index addr[31:2] >= DEPTH is out of range

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req  in  1  request strobe; sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
addr  in  32  byte address
wdata  in  32  store data; sub-word data taken from low bits
rdata  out  32  load result, registered
done  out  1  one-cycle completion pulse
addr_err  out  1  one-cycle error pulse, coincident with done
busy  out  1  high in every state except IDLE
dm_cs  out  1  DMEM chip select
dm_r  out  1  DMEM read strobe
dm_w  out  1  DMEM write strobe
dm_addr  out  32  DMEM address, always {word index, 2'b00}
dm_wdata  out  32  DMEM write data
dm_rdata  in  32  DMEM combinational read data for dm_addr

Behaviour:
- Reset: state=IDLE. rdata=0. done, addr_err, busy, dm_cs, dm_r and dm_w are 0. dm_addr=0, dm_wdata=0. Latched request registers are cleared.
- Byte lanes are little-endian. Byte k=addr[1:0] occupies bits [8k+7:8k]. Half h=addr[1] occupies bits [16h+15:16h].
- IDLE: on req=1, latch addr, we, size, sign_ext and wdata. Select the next state:
  - ERR if size=11, or half with addr[0]=1, or word with addr[1:0]!=0, or addr[31:2]>=DEPTH.
  - LOAD if we=0.
  - WRITE if word store.
  - RMW_RD if byte or half store.
- LOAD: dm_cs=1, dm_r=1. Capture the lane selected from dm_rdata, extend it per sign_ext, and write it into rdata. Next state DONE.
- RMW_RD: dm_cs=1, dm_r=1. Capture dm_rdata with the target lane replaced by wdata[7:0] or wdata[15:0] into a merge register. Next state WRITE.
- WRITE: dm_cs=1, dm_w=1. dm_wdata is the merge register for sub-word stores or the latched wdata for word stores. DMEM commits at the closing edge. Next state DONE.
- DONE: done=1. Next state IDLE.
- ERR: done=1, addr_err=1, no DMEM strobes. rdata is unchanged. Next state IDLE.
- All dm_* outputs are Moore outputs from state and latched registers; there is no combinational path from req or addr.
- Latency, with req accepted at edge T:
  - Load, word store or error: done at cycle T+2.
  - Sub-word store: done at cycle T+3.
  - Issue rate is one request per 3 or 4 cycles.
- Boundary rules:
  - req while busy is ignored, not queued.
  - req during the DONE cycle is ignored.
  - rdata holds its value until the next successful load.
  - Word stores never perform a read.
- Reset mid-operation:
  - rst sampled in LOAD or RMW_RD: no write occurs, return to IDLE, no done.
  - rst sampled at the edge closing a WRITE cycle: that DMEM write still commits, because dm_w was high during the cycle; the FSM returns to IDLE without done.

Decomposition:
- Shared package holds: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings (IDLE, LOAD, RMW_RD, WRITE, DONE, ERR), and the lane-select helper constants.
- One natural combinational sub-module, lsu_lane_mux, provides load extract/extend and store lane merge for a given addr[1:0], size and sign_ext.
- The FSM stays in dmem_lsu.

Test Plan:
- Preload mem[3]=0x8899AABB. Load byte, addr 0x0D, sign_ext=1 -> rdata=0xFFFFFFAA, done at T+2, addr_err=0.
- Same preload. Load half, addr 0x0E, sign_ext=0 -> rdata=0x00008899. Load word, addr 0x0C -> rdata=0x8899AABB.
- Same preload. Store byte, addr 0x0C, wdata=0x12345677 -> mem[3]=0x8899AA77. Expect dm_r in cycle T+1, dm_w in cycle T+2, done at T+3.
- Misaligned and out-of-range cases, each -> done=addr_err=1 at T+2, no dm_cs, memory and rdata unchanged:
  - Half load at addr 0x0D.
  - Word store at addr 0x100 with DEPTH=64.
  - size=11.
- Reset and busy handling:
  - Assert rst during RMW_RD of a half store to addr 0x0C -> mem[3] unchanged, busy=0 next cycle, no done.
  - req held high across a load -> exactly one access, second request accepted only after return to IDLE.
